// File: rtl/mips_defs_pkg.sv
// mips_defs: shared state/opcode/aluop encodings for the multicycle MIPS control path.
// Macro MAINCTL_ILLEGAL_TRAP_EN adds the HALT state for unrecognised opcodes.
package mips_defs;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
`ifdef MAINCTL_ILLEGAL_TRAP_EN
        ,
        HALT    = 4'd15
`endif
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/main_controller.sv
// main_controller: Moore control FSM sequencing byte-wise fetch, decode, execute, memory, writeback.
// Ports: clk, rst_n (async active-low); op, zero in; memory strobes, iord, irwrite, pcen,
// pcsource, alusrca/b, aluop, regwrite, regdst, memtoreg out; halted out with MAINCTL_ILLEGAL_TRAP_EN.
module main_controller
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
`ifdef MAINCTL_ILLEGAL_TRAP_EN
    ,
    output logic       halted
`endif
);

`ifdef MAINCTL_ILLEGAL_TRAP_EN
    localparam state_t BAD_OP_NEXT = HALT;
`else
    localparam state_t BAD_OP_NEXT = FETCH1;
`endif

    state_t     state, next;
    logic       pcwrite, pcwritecond, mw, rw;
    logic [3:0] irw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH1;
        else        state <= next;
    end

    always_comb begin
        next = FETCH1;
        case (state)
            FETCH1:  next = FETCH2;
            FETCH2:  next = FETCH3;
            FETCH3:  next = FETCH4;
            FETCH4:  next = DECODE;
            DECODE:  next = (op == OP_LB || op == OP_SB) ? MEMADR  :
                            (op == OP_RTYPE)             ? RTYPEEX :
                            (op == OP_BEQ)               ? BEQEX   :
                            (op == OP_J)                 ? JEX     :
                            (op == OP_ADDI)              ? ADDIEX  : BAD_OP_NEXT;
            MEMADR:  next = (op == OP_LB) ? LBRD : SBWR;
            LBRD:    next = LBWR;
            RTYPEEX: next = RTYPEWR;
            ADDIEX:  next = ADDIWR;
`ifdef MAINCTL_ILLEGAL_TRAP_EN
            HALT:    next = HALT;
`endif
            default: next = FETCH1;
        endcase
    end

    always_comb begin
        memread     = 1'b0;
        mw          = 1'b0;
        iord        = 1'b0;
        irw         = 4'b0000;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsource    = 2'b00;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = ALUOP_ADD;
        rw          = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                irw     = 4'b0001 << state[1:0];
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                rw       = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                mw   = 1'b1;
                iord = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                rw     = 1'b1;
                regdst = 1'b1;
            end
            BEQEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIWR:  rw = 1'b1;
            default: ;
        endcase
    end

    // State-changing strobes are held off while reset is low so an abandoned
    // instruction cannot commit anything during the reset window.
    assign pcen     = rst_n & (pcwrite | (pcwritecond & zero));
    assign irwrite  = rst_n ? irw : 4'b0000;
    assign regwrite = rst_n & rw;
    assign memwrite = rst_n & mw;

`ifdef MAINCTL_ILLEGAL_TRAP_EN
    assign halted = (state == HALT);
`endif

endmodule

// File: tb/tb_main_controller.sv
// tb_main_controller: directed stimulus with a cycle-indexed behavioural model and literal checks.
module tb_main_controller;

    typedef struct packed {
        logic       mr, mw, io;
        logic [3:0] ir;
        logic       pe;
        logic [1:0] ps;
        logic       sa;
        logic [1:0] sb, ao;
        logic       rw, rd, mt;
    } outs_t;

    localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;
`ifdef MAINCTL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk, rst_n, zero;
    logic [5:0] op;
    logic       memread, memwrite, iord, pcen, alusrca, regwrite, regdst, memtoreg;
    logic [3:0] irwrite;
    logic [1:0] pcsource, alusrcb, aluop;
    logic       halted_v;
    int         total = 0, bad = 0, mcyc;
    outs_t      dut_o, rec [1:24];
    logic       rh [1:24];

    main_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .pcsource(pcsource), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg)
`ifdef MAINCTL_ILLEGAL_TRAP_EN
        , .halted(halted_v)
`endif
    );

`ifndef MAINCTL_ILLEGAL_TRAP_EN
    assign halted_v = 1'b0;
`endif

    assign dut_o = {memread, memwrite, iord, irwrite, pcen, pcsource, alusrca, alusrcb, aluop, regwrite, regdst, memtoreg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ill(input logic [5:0] o);
        return !(o inside {LB, SB, RT, BEQ, JMP, ADDI});
    endfunction

    function automatic int len(input logic [5:0] o);
        case (o)
            LB:            return 8;
            SB, RT, ADDI:  return 7;
            BEQ, JMP:      return 6;
            default:       return 5;
        endcase
    endfunction

    // Expected outputs from the instruction's opcode and the cycle number within it.
    function automatic outs_t model(input logic [5:0] o, input int c, input logic z, input logic in_rst);
        outs_t e;
        e = '0;
        if (in_rst) begin
            e.mr = 1'b1; e.sb = 2'b01;
        end else if (c <= 4) begin
            e.mr = 1'b1; e.ir = 4'(1 << (c - 1)); e.sb = 2'b01; e.pe = 1'b1;
        end else if (c == 5) begin
            e.sb = 2'b11;
        end else if (c == 6) begin
            case (o)
                LB, SB, ADDI: begin e.sa = 1'b1; e.sb = 2'b10; end
                RT:           begin e.sa = 1'b1; e.ao = 2'b10; end
                BEQ:          begin e.sa = 1'b1; e.ao = 2'b01; e.ps = 2'b01; e.pe = z; end
                JMP:          begin e.pe = 1'b1; e.ps = 2'b10; end
                default: ;
            endcase
        end else if (c == 7) begin
            case (o)
                LB:      begin e.mr = 1'b1; e.io = 1'b1; end
                SB:      begin e.mw = 1'b1; e.io = 1'b1; end
                RT:      begin e.rw = 1'b1; e.rd = 1'b1; end
                ADDI:    e.rw = 1'b1;
                default: ;
            endcase
        end else if (c == 8 && o == LB) begin
            e.rw = 1'b1; e.mt = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           mcyc <= 1;
        else if (TRAP && ill(op) && mcyc >= 5) mcyc <= 6;
        else                                  mcyc <= (mcyc >= len(op)) ? 1 : mcyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("outs", 32'(dut_o), 32'(model(op, mcyc, zero, !rst_n)));
        if (TRAP) chk("halted", 32'(halted_v), 32'(rst_n && ill(op) && mcyc >= 6));
    end

    task automatic run(input logic [5:0] o, input logic z, input int n);
        op = o;
        zero = z;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            rec[i] = dut_o;
            rh[i] = halted_v;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] walk [1:4];
        logic       acc;
        walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst_n = 1'b0;
        op = LB;
        zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pcen", 32'(pcen), 0);
            chk("rst_irwrite", 32'(irwrite), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(LB, 1'b0, 8);
        for (int i = 1; i <= 4; i++) chk("lb_irwalk", 32'(rec[i].ir), 32'(walk[i]));
        chk("lb_memtoreg", 32'(rec[8].mt), 1);
        chk("lb_regwrite", 32'(rec[8].rw), 1);
        run(BEQ, 1'b1, 6);
        chk("beq1_aluop", 32'(rec[6].ao), 1);
        chk("beq1_pcsource", 32'(rec[6].ps), 1);
        chk("beq1_pcen", 32'(rec[6].pe), 1);
        run(BEQ, 1'b0, 6);
        chk("beq1_refetch", 32'(rec[1].ir), 1);
        chk("beq0_aluop", 32'(rec[6].ao), 1);
        chk("beq0_pcsource", 32'(rec[6].ps), 1);
        chk("beq0_pcen", 32'(rec[6].pe), 0);
        run(RT, 1'b0, 7);
        chk("beq0_refetch", 32'(rec[1].ir), 1);
        chk("rt_aluop", 32'(rec[6].ao), 2);
        chk("rt_alusrca", 32'(rec[6].sa), 1);
        chk("rt_regdst", 32'(rec[7].rd), 1);
        chk("rt_regwrite", 32'(rec[7].rw), 1);
        acc = 1'b0;
        for (int i = 1; i <= 7; i++) if (i != 6) acc |= |rec[i].ao;
        chk("rt_aluop_other", 32'(acc), 0);
        run(SB, 1'b0, 7);
        chk("sb_memwrite", 32'(rec[7].mw), 1);
        chk("sb_iord", 32'(rec[7].io), 1);
        acc = 1'b0;
        for (int i = 1; i <= 7; i++) acc |= rec[i].rw | ((i != 7) & (rec[i].mw | rec[i].io));
        chk("sb_quiet", 32'(acc), 0);
        run(ADDI, 1'b0, 7);
        chk("addi_regwrite", 32'(rec[7].rw), 1);
        chk("addi_regdst", 32'(rec[7].rd), 0);
        run(JMP, 1'b0, 6);
        chk("j_pcen", 32'(rec[6].pe), 1);
        chk("j_pcsource", 32'(rec[6].ps), 2);
`ifdef MAINCTL_ILLEGAL_TRAP_EN
        run(ILL, 1'b0, 20);
        acc = 1'b0;
        for (int i = 6; i <= 20; i++) acc |= !rh[i] | rec[i].mr | rec[i].mw | rec[i].pe | rec[i].rw | (|rec[i].ir);
        chk("halt_hold", 32'(acc), 0);
        chk("halt_not_early", 32'(rh[5]), 0);
        #2 rst_n = 1'b0;
        #1 chk("halt_rst", 32'(halted_v), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(RT, 1'b0, 5);
`else
        run(ILL, 1'b0, 5);
        run(RT, 1'b0, 5);
        chk("ill_nop_refetch", 32'(rec[1].ir), 1);
`endif
        chk("rtex_aluop", 32'(aluop), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_aluop", 32'(aluop), 0);
        chk("midrst_alusrca", 32'(alusrca), 0);
        chk("midrst_alusrcb", 32'(alusrcb), 1);
        chk("midrst_memread", 32'(memread), 1);
        chk("midrst_regwrite", 32'(regwrite), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(LB, 1'b0, 8);
        chk("postrst_fetch", 32'(rec[1].ir), 1);
        acc = 1'b0;
        for (int i = 1; i <= 7; i++) acc |= rec[i].rw;
        chk("postrst_no_regwrite", 32'(acc), 0);
        chk("postrst_lb_wb", 32'(rec[8].rw & rec[8].mt), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
